// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the ALU function-sweep controller.
package alu_pkg;

    localparam int unsigned FXN_W     = 3;
    localparam int unsigned NUM_FXN   = 8;
    localparam int unsigned DEF_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/alu_result_buf.sv
// Eight-slot result store: one write port, one combinational read port,
// all slots cleared synchronously while rst_n is low.
module alu_result_buf
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [FXN_W-1:0]   wr_idx,
    input  logic [WIDTH+1:0]   wr_data,
    input  logic [FXN_W-1:0]   rd_idx,
    output logic [WIDTH+1:0]   rd_data
);

    logic [WIDTH+1:0] mem [NUM_FXN];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_FXN; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/alu_sweep_ctrl.sv
// Drives latched operands through all eight ALU function codes, holding each
// for SETTLE cycles, and records {cout, oflow, out} per code for readback.
module alu_sweep_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [FXN_W-1:0]   alu_fxn,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic               alu_oflow,
    input  logic               alu_cout,
    output logic               busy,
    output logic               done,
    input  logic [FXN_W-1:0]   rd_idx,
    output logic [WIDTH+1:0]   rd_data,
    output logic [3:0]         oflow_cnt
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [FXN_W-1:0] FXN_LAST    = FXN_W'(NUM_FXN - 1);

    sweep_state_t     state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [FXN_W-1:0] fxn_q, fxn_d;
    logic [3:0]       settle_q, settle_d;
    logic [3:0]       ocnt_q, ocnt_d;
    logic             wr_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            fxn_q    <= '0;
            settle_q <= '0;
            ocnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            fxn_q    <= fxn_d;
            settle_q <= settle_d;
            ocnt_q   <= ocnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        fxn_d    = fxn_q;
        settle_d = settle_q;
        ocnt_d   = ocnt_q;
        wr_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                fxn_d = '0;
                if (start) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    settle_d = '0;
                    ocnt_d   = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Capture on the final settle cycle of each function code.
                if (settle_q == SETTLE_LAST) begin
                    wr_en    = 1'b1;
                    ocnt_d   = ocnt_q + 4'(alu_oflow);
                    settle_d = '0;
                    if (fxn_q == FXN_LAST) begin
                        state_d = DONE;
                    end else begin
                        fxn_d = fxn_q + 1'b1;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                fxn_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    alu_result_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (fxn_q),
        .wr_data ({alu_cout, alu_oflow, alu_out}),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_fxn   = fxn_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign oflow_cnt = ocnt_q;

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Directed bench: stub ALU out = a ^ fxn, oflow = fxn[0], cout = fxn[1].
module tb_alu_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start2;
    logic [5:0] op_a1, op_b1, op_a2, op_b2;
    logic [5:0] a1, b1, a2, b2;
    logic [2:0] fxn1, fxn2;
    logic       busy1, done1, busy2, done2;
    logic [2:0] rd_idx1, rd_idx2;
    logic [7:0] rd_data1, rd_data2;
    logic [3:0] ocnt1, ocnt2;
    logic [5:0] out1, out2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign out1 = a1 ^ {3'b000, fxn1};
    assign out2 = a2 ^ {3'b000, fxn2};

    alu_sweep_ctrl #(.WIDTH(6), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a1), .op_b(op_b1),
        .alu_a(a1), .alu_b(b1), .alu_fxn(fxn1), .alu_out(out1),
        .alu_oflow(fxn1[0]), .alu_cout(fxn1[1]), .busy(busy1), .done(done1),
        .rd_idx(rd_idx1), .rd_data(rd_data1), .oflow_cnt(ocnt1)
    );

    alu_sweep_ctrl #(.WIDTH(6), .SETTLE(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op_a(op_a2), .op_b(op_b2),
        .alu_a(a2), .alu_b(b2), .alu_fxn(fxn2), .alu_out(out2),
        .alu_oflow(fxn2[0]), .alu_cout(fxn2[1]), .busy(busy2), .done(done2),
        .rd_idx(rd_idx2), .rd_data(rd_data2), .oflow_cnt(ocnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] exp_entry(input logic [5:0] a, input int k);
        logic [2:0] f;
        f = 3'(k);
        return {f[1], f[0], a ^ {3'b000, f}};
    endfunction

    task automatic check_slots1(input string tag, input logic [5:0] a, input bit zero);
        for (int k = 0; k < 8; k++) begin
            rd_idx1 = 3'(k);
            #1;
            check(tag, rd_data1, zero ? 8'h00 : exp_entry(a, k));
        end
    endtask

    initial begin
        int bc, dc, gap, ph;
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
        op_a1 = '0; op_b1 = '0; op_a2 = '0; op_b2 = '0;
        rd_idx1 = '0; rd_idx2 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_alu_a", a1, 0);
        check("rst_fxn", fxn1, 0);
        check("rst_ocnt", ocnt1, 0);
        check_slots1("rst_slot", 6'd0, 1'b1);
        rst_n = 1'b1;

        // Basic sweep, SETTLE=2
        op_a1 = 6'b000111; op_b1 = 6'b111111; start1 = 1'b1;
        bc = 0; dc = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            if (busy1) bc++;
            if (done1) dc++;
            if (bc > 0 && !busy1) break;
        end
        check("sweep_busy_cycles", bc, 17);
        check("sweep_done_pulses", dc, 1);
        check("sweep_ocnt", ocnt1, 4);
        check("sweep_fxn_idle", fxn1, 0);
        check("sweep_hold_a", a1, 6'b000111);
        check("sweep_hold_b", b1, 6'b111111);
        check_slots1("sweep_slot", 6'b000111, 1'b0);

        // Start pulses during the sweep are ignored
        op_a1 = 6'b000111; start1 = 1'b1;
        bc = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            op_a1 = 6'b110011;
            if (busy1) begin
                bc++;
                check("ign_alu_a", a1, 6'b000111);
            end
            start1 = (bc > 0 && bc < 12) ? bc[0] : 1'b0;
            if (bc > 0 && !busy1) break;
        end
        check("ign_busy_cycles", bc, 17);
        check("ign_ocnt", ocnt1, 4);
        check_slots1("ign_slot", 6'b000111, 1'b0);

        // Reset mid-sweep at fxn=3
        op_a1 = 6'b010101; start1 = 1'b1;
        dc = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            if (done1) dc++;
            if (fxn1 == 3'd3) break;
        end
        check("abort_reached_fxn3", fxn1, 3);
        rst_n = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy1, 0);
        check("abort_done", done1, 0);
        check("abort_no_done_seen", dc, 0);
        check("abort_fxn", fxn1, 0);
        check("abort_ocnt", ocnt1, 0);
        check("abort_alu_a", a1, 0);
        check_slots1("abort_slot", 6'd0, 1'b1);
        rst_n = 1'b1; start1 = 1'b0;
        @(posedge clk); #1;
        check("abort_stays_idle", busy1, 0);

        // Back-to-back sweeps with start held high
        op_a1 = 6'b000111; op_b1 = 6'b111111; start1 = 1'b1;
        ph = 0; gap = 0; bc = 0; dc = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (done1) dc++;
            if (ph == 0) begin
                if (done1) begin
                    ph = 1;
                    op_a1 = 6'b101010;
                end
            end else if (ph == 1) begin
                if (!busy1) gap++;
                else begin
                    ph = 2; start1 = 1'b0; bc = 1;
                    rd_idx1 = 3'd7; #1;
                    check("b2b_retain_slot7", rd_data1, exp_entry(6'b000111, 7));
                end
            end else begin
                if (busy1) bc++;
                else break;
            end
        end
        check("b2b_idle_gap", gap, 1);
        check("b2b_busy_cycles", bc, 17);
        check("b2b_done_pulses", dc, 2);
        check("b2b_alu_a", a1, 6'b101010);
        check("b2b_ocnt", ocnt1, 4);
        check_slots1("b2b_slot", 6'b101010, 1'b0);

        // SETTLE=1 instance
        op_a2 = 6'b111000; op_b2 = 6'b000001; start2 = 1'b1;
        bc = 0; dc = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            if (busy2) begin
                bc++;
                if (bc <= 8) check("s1_fxn_step", fxn2, 32'(bc - 1));
            end
            if (done2) dc++;
            if (bc > 0 && !busy2) break;
        end
        check("s1_busy_cycles", bc, 9);
        check("s1_done_pulses", dc, 1);
        check("s1_ocnt", ocnt2, 4);
        for (int k = 0; k < 8; k++) begin
            rd_idx2 = 3'(k);
            #1;
            check("s1_slot", rd_data2, exp_entry(6'b111000, k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sweep_ctrl.md
ALU_SWEEP_CTRL -- requirements
Module: alu_sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 6, operand and result width (matches the mini-ALU datapath).
REQ-002 Parameter SETTLE, default 2, cycles each function code is held on the ALU before capture (legal range 1..15).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port start  input  1  request a sweep; sampled only in IDLE.
REQ-006 Port op_a  input  WIDTH  operand A, latched on start acceptance.
REQ-007 Port op_b  input  WIDTH  operand B, latched on start acceptance.
REQ-008 Port alu_a  output  WIDTH  operand A driven to the downstream ALU input_a.
REQ-009 Port alu_b  output  WIDTH  operand B driven to the downstream ALU input_b.
REQ-010 Port alu_fxn  output  3  function code driven to the downstream ALU fxn.
REQ-011 Port alu_out  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_fxn).
REQ-012 Port alu_oflow  input  1  ALU overflow flag.
REQ-013 Port alu_cout  input  1  ALU carry-out flag.
REQ-014 Port busy  output  1  high while a sweep is in progress.
REQ-015 Port done  output  1  one-cycle pulse when all 8 results are captured.
REQ-016 Port rd_idx  input  3  readback slot select (function code).
REQ-017 Port rd_data  output  WIDTH+2  captured entry {cout, oflow, out} for slot rd_idx.
REQ-018 Port oflow_cnt  output  4  count of captured entries with oflow=1 in the current/last sweep (0..8).

Function
REQ-019 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-020 IDLE with start=1 SHALL latch op_a/op_b into alu_a/alu_b, set alu_fxn=0, clear settle counter and oflow_cnt, go to RUN.
REQ-021 RUN SHALL hold each alu_fxn value for exactly SETTLE cycles; on the last of those cycles it SHALL write {alu_cout, alu_oflow, alu_out} into slot alu_fxn and add alu_oflow to oflow_cnt.
REQ-022 After capturing slot 7, RUN SHALL go to DONE; otherwise alu_fxn increments by 1 with no wrap inside a sweep.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE; alu_fxn returns to 0 in IDLE.
REQ-024 busy SHALL be 1 in RUN and DONE, 0 in IDLE; total busy cycles per sweep = 8*SETTLE+1.
REQ-025 start in RUN or DONE SHALL be ignored (no queueing); operands SHALL NOT change during a sweep.
REQ-026 alu_a/alu_b SHALL hold the last latched operands in IDLE.
REQ-027 rd_data SHALL be combinational from the buffer and rd_idx, readable in any state; a slot written in cycle N is visible from cycle N+1.
REQ-028 Slots not yet rewritten in a sweep SHALL keep the previous sweep's values.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, alu_a=alu_b=0, alu_fxn=0, busy=0, done=0, oflow_cnt=0, all 8 buffer slots=0, settle counter=0.
REQ-030 Reset asserted mid-sweep SHALL abort immediately with no done pulse; start with rst_n=0 is ignored.

Structure
REQ-031 Package alu_pkg SHALL hold FXN_W=3, NUM_FXN=8, the default WIDTH, and the FSM state enum.
REQ-032 The 8-entry (WIDTH+2)-bit result store SHALL be a sub-module alu_result_buf (one write port, one combinational read port, synchronous clear on reset).

Verification (bench stub ALU: alu_out = alu_a ^ {000,alu_fxn}, alu_oflow = alu_fxn[0], alu_cout = alu_fxn[1])
REQ-033 Reset, then start with op_a=000111, op_b=111111, SETTLE=2 -> busy for 17 cycles, done pulses once, slot k reads {k[1], k[0], 000111^k}, oflow_cnt=4.
REQ-034 Pulse start repeatedly during RUN with different op_a -> ignored; alu_a stays 000111 and results match REQ-033.
REQ-035 Assert rst_n=0 when alu_fxn=3 -> next cycle IDLE, busy=0, no done, all slots read 0, oflow_cnt=0.
REQ-036 Back-to-back sweeps (start held high) -> second sweep starts the cycle after DONE; second op_a=101010 overwrites all slots.
REQ-037 SETTLE=1 -> busy exactly 9 cycles, alu_fxn advances every cycle, captures correct.
